// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder: immediate formats,
// FSM states, opcode values and immediate field widths.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // Signed widths of the immediates (I and S share 12 bits).
    localparam int unsigned IMM_I_BITS = 12;
    localparam int unsigned IMM_B_BITS = 13;
    localparam int unsigned IMM_J_BITS = 21;

    // True when v is representable as a two's-complement number of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake and instruction-memory write port of the encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic        in_valid;
    logic        in_ready;
    imm_fmt_e    fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready,
        output imem_ready,
        input  imem_we, imem_addr, imem_wdata, imem_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready,
        input  imem_ready,
        output imem_we, imem_addr, imem_wdata, imem_err
    );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer; with IMM_CHECK_EN defined it also flags
// immediates that cannot be represented exactly in the chosen format.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  imm_fmt_e    fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    always_comb begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef IMM_CHECK_EN
    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: err = !fits_signed(imm, IMM_I_BITS);
            FMT_B:        err = !fits_signed(imm, IMM_B_BITS) || imm[0];
            FMT_J:        err = !fits_signed(imm, IMM_J_BITS) || imm[0];
            FMT_U:        err = |imm[11:0];
            default:      err = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV32I words into instruction memory for a start/length-controlled run.
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     run_len,
    output logic            busy,
    output logic            done,
    instr_encoder_if.slave  bus
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((IMEM_DEPTH - 1) * 4);

    enc_state_e  state;
    enc_state_e  state_nxt;

    logic [15:0] acc_left;
    logic [15:0] wr_left;
    logic        accept;
    logic        wr_hs;
    logic        last_wr;
    logic [31:0] pack_word;
    logic        pack_err;
    logic [31:0] addr_nxt;

    instr_pack u_pack (
        .fmt    (bus.fmt),
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .imm    (bus.imm),
        .word   (pack_word),
        .err    (pack_err)
    );

    // A new bundle may enter whenever the output register is empty or drains this cycle.
    assign bus.in_ready = (state == ST_RUN) && (acc_left != '0)
                          && (!bus.imem_we || bus.imem_ready);

    assign accept   = bus.in_valid && bus.in_ready;
    assign wr_hs    = bus.imem_we && bus.imem_ready;
    assign last_wr  = wr_hs && (wr_left == 16'd1);
    assign addr_nxt = (bus.imem_addr == LAST_ADDR) ? BASE_ADDR : bus.imem_addr + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (run_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_wr) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accept and write counters run independently so DONE waits for the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_left       <= '0;
            wr_left        <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
            bus.imem_err   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                acc_left      <= run_len;
                wr_left       <= run_len;
                bus.imem_addr <= BASE_ADDR;
            end else begin
                if (accept) begin
                    acc_left <= acc_left - 16'd1;
                end
                if (wr_hs) begin
                    wr_left       <= wr_left - 16'd1;
                    bus.imem_addr <= addr_nxt;
                end
            end

            if (accept) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= pack_word;
                bus.imem_err   <= pack_err;
            end else if (wr_hs) begin
                bus.imem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, stalls, ignored start,
// empty run, mid-run reset and a random encode/decode round trip.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef IMM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] run_len = '0;
    logic        busy;
    logic        done;

    instr_encoder_if bus();

    instr_encoder #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .run_len (run_len),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        imm_fmt_e    fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        chk_word;
        logic        err;
        logic [31:0] addr;
    } sb_item_t;

    sb_item_t    sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    int          stall_word = -1;
    int          stall_left = 0;
    logic [31:0] exp_addr = BASE;
    logic        abort = 1'b0;
    logic        rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] hold_w;
    logic [31:0] hold_a;
    logic        hold_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Immediate as an RV32I decoder would recover it from the instruction word.
    function automatic logic [31:0] dec_imm(input imm_fmt_e f, input logic [31:0] w);
        case (f)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'b0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // Value the immediate takes once truncated to the format's field.
    function automatic logic [31:0] canon(input imm_fmt_e f, input logic [31:0] i);
        case (f)
            FMT_I, FMT_S: return {{20{i[11]}}, i[11:0]};
            FMT_B:        return {{19{i[12]}}, i[12:1], 1'b0};
            FMT_U:        return {i[31:12], 12'b0};
            FMT_J:        return {{11{i[20]}}, i[20:1], 1'b0};
            default:      return '0;
        endcase
    endfunction

    function automatic sb_item_t mk(input imm_fmt_e f, input logic [6:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm,
                                    input logic [31:0] word, input logic chk,
                                    input logic err);
        sb_item_t it;
        it.fmt = f;  it.op = op;  it.rd = rd;  it.rs1 = rs1;  it.rs2 = rs2;
        it.f3 = f3;  it.f7 = f7;  it.imm = imm;  it.word = word;
        it.chk_word = chk;  it.err = err;  it.addr = '0;
        return it;
    endfunction

    function automatic sb_item_t rand_item();
        sb_item_t    it;
        logic [31:0] r;
        imm_fmt_e    f;
        f = imm_fmt_e'(3'($urandom_range(0, 5)));
        r = $urandom;
        it = mk(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), r, '0, 1'b0, 1'b0);
        case (f)
            FMT_I, FMT_S: it.imm = {{20{r[11]}}, r[11:0]};
            FMT_B:        it.imm = {{19{r[12]}}, r[12:1], 1'b0};
            FMT_J:        it.imm = {{11{r[20]}}, r[20:1], 1'b0};
            FMT_U:        it.imm = {r[31:12], 12'b0};
            default:      it.imm = r;
        endcase
        return it;
    endfunction

    task automatic score(input logic [31:0] w);
        sb_item_t it;
        check("sb_pending", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            it = sbq.pop_front();
            check("addr", bus.imem_addr, it.addr);
            check("err", 32'(bus.imem_err), 32'(it.err));
            if (it.chk_word) check("wdata", w, it.word);
            check("rt_op", 32'(w[6:0]), 32'(it.op));
            check("rt_imm", dec_imm(it.fmt, w), canon(it.fmt, it.imm));
            if (it.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) check("rt_rd", 32'(w[11:7]), 32'(it.rd));
            if (it.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
                check("rt_rs1", 32'(w[19:15]), 32'(it.rs1));
                check("rt_f3", 32'(w[14:12]), 32'(it.f3));
            end
            if (it.fmt inside {FMT_R, FMT_S, FMT_B}) check("rt_rs2", 32'(w[24:20]), 32'(it.rs2));
            if (it.fmt == FMT_R) check("rt_f7", 32'(w[31:25]), 32'(it.f7));
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.imem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_word >= 0 && wr_seen == stall_word && bus.imem_we && stall_left > 0) begin
                bus.imem_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus.imem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.imem_ready = 1'b1;
            end
        end
    end

    // Output monitor: write handshakes, hold-while-stalled and done pulses.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_we", 32'(bus.imem_we), 32'd1);
                check("hold_wdata", bus.imem_wdata, hold_w);
                check("hold_addr", bus.imem_addr, hold_a);
                check("hold_err", 32'(bus.imem_err), 32'(hold_e));
            end
            if (bus.imem_we && bus.imem_ready) begin
                wr_seen++;
                last_wr_cyc = cyc;
                score(bus.imem_wdata);
            end
            prev_stall = bus.imem_we && !bus.imem_ready;
            hold_w = bus.imem_wdata;
            hold_a = bus.imem_addr;
            hold_e = bus.imem_err;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(input sb_item_t it_in);
        sb_item_t it;
        int       n;
        it = it_in;
        n = 0;
        bus.fmt = it.fmt;  bus.opcode = it.op;  bus.rd = it.rd;  bus.rs1 = it.rs1;
        bus.rs2 = it.rs2;  bus.funct3 = it.f3;  bus.funct7 = it.f7;  bus.imm = it.imm;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (abort) break;
            if (bus.in_ready) begin
                it.addr = exp_addr;
                exp_addr = BASE + ((exp_addr - BASE + 32'd4) % (DEPTH * 4));
                sbq.push_back(it);
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 2000) begin
                check("accept_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic start_run(input int len);
        @(posedge clk);
        #1;
        start = 1'b1;
        run_len = 16'(len);
        exp_addr = BASE;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        int n;
        bus.in_valid = 1'b0;
        bus.fmt = FMT_R;  bus.opcode = '0;  bus.rd = '0;  bus.rs1 = '0;
        bus.rs2 = '0;  bus.funct3 = '0;  bus.funct7 = '0;  bus.imm = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", bus.imem_addr, BASE);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_err", 32'(bus.imem_err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single I-type word and done latency.
        d0 = done_cnt;
        start_run(1);
        send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b1, 1'b0));
        wait_done(d0, "run1");
        check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);

        // Four words with a 3-cycle stall on the second, plus a start while busy.
        d0 = done_cnt;
        w0 = wr_seen;
        stall_word = wr_seen + 1;
        stall_left = 3;
        start_run(4);
        send(mk(FMT_S, 7'h23, 5'd0, 5'd1, 5'd3, 3'd2, 7'd0, 32'd0, 32'h0030A023, 1'b1, 1'b0));
        start = 1'b1;
        run_len = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4, 32'h00208263, 1'b1, 1'b0));
        send(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h004000EF, 1'b1, 1'b0));
        send(mk(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1, 1'b0));
        wait_done(d0, "run4");
        check("run4_writes", 32'(wr_seen - w0), 32'd4);
        check("run4_stalled", 32'(stall_left), 32'd0);
        stall_word = -1;

        // Empty run goes straight to DONE.
        d0 = done_cnt;
        w0 = wr_seen;
        start_run(0);
        wait_done(d0, "run0");
        check("run0_writes", 32'(wr_seen - w0), 32'd0);

        // Bundles offered while idle are refused.
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        check("idle_we", 32'(bus.imem_we), 32'd0);
        bus.in_valid = 1'b0;

        // Out-of-range immediates are truncated; flagged only with checking enabled.
        d0 = done_cnt;
        start_run(6);
        send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1, CHECK_EN));
        send(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6, 32'h00208363, 1'b1, 1'b0));
        send(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 32'h00208263, 1'b1, CHECK_EN));
        send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00100093, 1'b1, CHECK_EN));
        send(mk(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678, 32'h123452B7, 1'b1, CHECK_EN));
        send(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h800000EF, 1'b1, CHECK_EN));
        wait_done(d0, "immchk");

        // Reset after three writes of an eight-word run.
        w0 = wr_seen;
        start_run(8);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (!abort) send(rand_item());
                end
            end
            begin
                n = 0;
                while (wr_seen < w0 + 3 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_mid_reached", 32'(wr_seen - w0), 32'd3);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                d0 = done_cnt;
                check("mid_rst_we", 32'(bus.imem_we), 32'd0);
                check("mid_rst_addr", bus.imem_addr, BASE);
                check("mid_rst_wdata", bus.imem_wdata, 32'd0);
                check("mid_rst_err", 32'(bus.imem_err), 32'd0);
                check("mid_rst_done", 32'(done), 32'd0);
                check("mid_rst_busy", 32'(busy), 32'd0);
                check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
            end
        join
        sbq.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        start_run(1);
        send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b1, 1'b0));
        wait_done(d0, "restart");

        // Random round trip with random write back-pressure; wraps the address space.
        d0 = done_cnt;
        w0 = wr_seen;
        rand_ready = 1'b1;
        start_run(10000);
        for (int i = 0; i < 10000; i++) send(rand_item());
        wait_done(d0, "random");
        rand_ready = 1'b0;
        check("random_writes", 32'(wr_seen - w0), 32'd10000);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
